// File: rtl/timer_counter.sv
// timer_counter
//   Memory-mapped down-counting timer. The processor programs CTRL and
//   PRESET through bridge word writes. Once enabled, the counter loads
//   PRESET, decrements once per clock and raises an interrupt flag on
//   expiry. Mode 0 is one-shot: En self-clears and the flag is sticky until
//   the next CTRL write. Any non-zero mode is auto-reload: the flag pulses
//   for one cycle and the count reloads while En stays set.
//
//   Register map (addr[3:2]):
//     0 CTRL   RW  [0] En, [2:1] Mode, [3] IM; upper bits read 0
//     1 PRESET RW  reload value, used at the next LOAD
//     2 COUNT  RO  current count; writes ignored
//     3 --         reads 0; writes ignored
//
// Ports
//   clk    in   1   system clock, all state updates on the rising edge
//   rst_n  in   1   asynchronous active-low reset
//   addr   in  30   word address (byte address [31:2]); only [3:2] decoded
//   we     in   1   write strobe, asserted only inside this timer's window
//   wdata  in  32   write data
//   rdata  out 32   combinational read data for addr[3:2]
//   irq    out  1   interrupt request = IM & irq_flag

module timer_counter #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:2] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   state_t      state, state_nxt;
   logic        en, en_nxt;
   logic [1:0]  mode, mode_nxt;
   logic        im, im_nxt;
   logic [31:0] preset, preset_nxt;
   logic [31:0] count, count_nxt;
   logic        irq_flag, irq_flag_nxt;

   logic        ctrl_wr;
   logic        preset_wr;

   // The bridge already qualifies the window, so the upper address bits and
   // the base address are intentionally not decoded here.
   logic        unused_bits;
   assign unused_bits = ^{addr[31:4], BASE_ADDR};

   assign ctrl_wr   = we && (addr[3:2] == REG_CTRL);
   assign preset_wr = we && (addr[3:2] == REG_PRESET);

   // Next-state and datapath. The FSM proposes updates first; CPU writes are
   // applied afterwards so a CTRL write wins over the FSM clearing En in INT,
   // and any CTRL write clears irq_flag even on the edge that would set it.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned; a missing default here would infer a latch.
      state_nxt    = state;
      en_nxt       = en;
      mode_nxt     = mode;
      im_nxt       = im;
      preset_nxt   = preset;
      count_nxt    = count;
      irq_flag_nxt = irq_flag;

      unique case (state)
         IDLE: begin
            if (en) state_nxt = LOAD;
         end
         LOAD: begin
            count_nxt = preset;
            state_nxt = CNT;
         end
         CNT: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (count > 32'd1) begin
               count_nxt = count - 32'd1;
            end else begin
               // PRESET of 0 or 1 both land here: clamp at 0, never wrap.
               count_nxt    = '0;
               irq_flag_nxt = 1'b1;
               state_nxt    = INT;
            end
         end
         INT: begin
            if (mode == 2'b00) en_nxt = 1'b0;
            else               irq_flag_nxt = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (ctrl_wr) begin
         en_nxt       = wdata[0];
         mode_nxt     = wdata[2:1];
         im_nxt       = wdata[3];
         irq_flag_nxt = 1'b0;
      end
      if (preset_wr) preset_nxt = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         en       <= 1'b0;
         mode     <= 2'b00;
         im       <= 1'b0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         state    <= state_nxt;
         en       <= en_nxt;
         mode     <= mode_nxt;
         im       <= im_nxt;
         preset   <= preset_nxt;
         count    <= count_nxt;
         irq_flag <= irq_flag_nxt;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (addr[3:2])
         REG_CTRL:   rdata = {28'b0, im, mode, en};
         REG_PRESET: rdata = preset;
         REG_COUNT:  rdata = count;
         default:    rdata = '0;
      endcase
   end

   assign irq = im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with literal
// expectations, then randomized bus traffic checked every cycle against a
// behavioural model of the timer.

module tb_timer_counter;

   localparam logic [31:0] BASE = 32'h0000_7F00;

   logic        clk;
   logic        rst_n;
   logic [31:2] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   timer_counter #(.BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_on  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 waiting for enable, 1 reload pending, 2 counting, 3 expired
   logic        m_en, m_im, m_flag;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_count;
   int          m_phase;

   task automatic model_reset();
      m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
      m_preset = 0; m_count = 0; m_phase = 0;
   endtask

   task automatic model_step(input logic w, input logic [1:0] a, input logic [31:0] d);
      int ph;
      ph = m_phase;
      if (ph == 0) begin
         if (m_en) m_phase = 1;
      end else if (ph == 1) begin
         m_count = m_preset;
         m_phase = 2;
      end else if (ph == 2) begin
         if (!m_en) m_phase = 0;
         else begin
            if (m_count <= 1) begin
               m_flag  = 1;
               m_phase = 3;
            end
            m_count = (m_count > 1) ? m_count - 1 : 32'd0;
         end
      end else begin
         if (m_mode == 0) m_en = 0;
         else             m_flag = 0;
         m_phase = 0;
      end
      if (w && a == 2'd0) begin
         m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
      end
      if (w && a == 2'd1) m_preset = d;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return {28'b0, m_im, m_mode, m_en};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   // Single compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("cmp_rdata", rdata, model_read(addr[3:2]));
         check("cmp_irq", {31'b0, irq}, {31'b0, m_im & m_flag});
      end
   end

   // One bus cycle: drive inputs, let one rising edge happen, advance model.
   task automatic tick(input logic w, input logic [1:0] a, input logic [31:0] d);
      we    = w;
      addr  = {BASE[31:4], a};
      wdata = d;
      @(posedge clk);
      if (rst_n) model_step(w, a, d);
      #2;
      we = 1'b0;
   endtask

   task automatic read_all_zero(input string name);
      for (int a = 0; a < 4; a++) begin
         addr = {BASE[31:4], 2'(a)};
         #1;
         check(name, rdata, 32'd0);
      end
      check({name, "_irq"}, {31'b0, irq}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      we    = 1'b0;
      addr  = {BASE[31:4], 2'd0};
      wdata = '0;
      model_reset();
      cmp_on = 1'b1;

      // Power-on reset state.
      repeat (2) @(posedge clk);
      #2;
      read_all_zero("por_zero");
      @(negedge clk);
      rst_n = 1'b1;
      tick(0, 0, 0);

      // 1: reset mid-count.
      tick(1, 1, 5);
      tick(1, 0, 9);
      repeat (3) tick(0, 2, 0);
      check("rst_mid_count", rdata, 32'd4);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      read_all_zero("rst_async_zero");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick(0, 2, 0);
         check("rst_after_irq", {31'b0, irq}, 32'd0);
         check("rst_after_count", rdata, 32'd0);
      end

      // 2: one-shot, PRESET=3, irq 5 cycles after enable edge.
      tick(1, 1, 3);
      tick(1, 0, 9);
      for (int k = 1; k <= 5; k++) begin
         tick(0, 0, 0);
         check("os_irq_timing", {31'b0, irq}, (k == 5) ? 32'd1 : 32'd0);
      end
      tick(0, 0, 0);
      check("os_ctrl_after", rdata, 32'h8);
      check("os_irq_sticky", {31'b0, irq}, 32'd1);
      tick(1, 0, 0);
      check("os_irq_cleared", {31'b0, irq}, 32'd0);
      repeat (2) tick(0, 2, 0);

      // 3: auto-reload, PRESET=2, 5-cycle period, COUNT 2,1,0,0,0.
      tick(1, 1, 2);
      tick(1, 0, 11);
      for (int k = 1; k <= 14; k++) begin
         tick(0, 2, 0);
         check("ar_irq_pulse", {31'b0, irq}, (k % 5 == 4) ? 32'd1 : 32'd0);
         if (k >= 2)
            check("ar_count_seq", rdata,
                  ((k - 2) % 5 == 0) ? 32'd2 : ((k - 2) % 5 == 1) ? 32'd1 : 32'd0);
      end
      tick(1, 0, 0);
      repeat (3) tick(0, 2, 0);

      // 4: disable mid-count, then re-enable reloads.
      tick(1, 1, 10);
      tick(1, 0, 9);
      for (int k = 1; k <= 6; k++) tick(0, 2, 0);
      check("dis_count6", rdata, 32'd6);
      tick(1, 0, 8);
      for (int k = 0; k < 5; k++) begin
         tick(0, 2, 0);
         check("dis_frozen", rdata, 32'd5);
         check("dis_no_irq", {31'b0, irq}, 32'd0);
      end
      tick(1, 0, 9);
      tick(0, 2, 0);
      tick(0, 2, 0);
      check("dis_reload", rdata, 32'd10);
      tick(1, 0, 0);
      repeat (3) tick(0, 2, 0);

      // 5: PRESET 0 and 1 expire 3 cycles after enable.
      for (int p = 0; p < 2; p++) begin
         tick(1, 1, 32'(p));
         tick(1, 0, 9);
         for (int k = 1; k <= 3; k++) begin
            tick(0, 2, 0);
            check("edge_irq_timing", {31'b0, irq}, (k == 3) ? 32'd1 : 32'd0);
         end
         check("edge_count_zero", rdata, 32'd0);
         tick(1, 0, 0);
         repeat (2) tick(0, 2, 0);
      end
      // COUNT write ignored while counting; reserved reads 0.
      tick(1, 1, 7);
      tick(1, 0, 1);
      tick(0, 2, 0);
      tick(0, 2, 0);
      tick(1, 2, 32'hDEAD_BEEF);
      check("cnt_write_ignored", rdata, 32'd6);
      tick(1, 3, 32'hFFFF_FFFF);
      check("reserved_reads0", rdata, 32'd0);
      tick(1, 0, 0);
      repeat (3) tick(0, 2, 0);

      // 6: masked expiry, flag clear, and CTRL write colliding with INT.
      tick(1, 1, 2);
      tick(1, 0, 1);
      for (int k = 1; k <= 6; k++) begin
         tick(0, 2, 0);
         check("mask_irq_low", {31'b0, irq}, 32'd0);
      end
      tick(1, 0, 8);
      check("mask_irq_after_im", {31'b0, irq}, 32'd0);
      check("mask_ctrl", rdata, 32'h8);
      tick(1, 0, 9);
      for (int k = 1; k <= 4; k++) tick(0, 0, 0);
      check("conf_in_int", {31'b0, irq}, 32'd1);
      tick(1, 0, 11);
      check("conf_ctrl_wins", rdata, 32'd11);
      check("conf_irq_clear", {31'b0, irq}, 32'd0);
      tick(1, 0, 0);
      repeat (3) tick(0, 2, 0);

      // Randomized traffic, checked by the per-cycle compare process.
      for (int i = 0; i < 3000; i++) begin
         int r;
         int sel;
         logic [31:0] p;
         r = $urandom_range(0, 99);
         if (i == 1500) begin
            #1;
            rst_n = 1'b0;
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
         end
         if (r < 6) begin
            tick(1, 0, $urandom | ((r < 4) ? 32'd1 : 32'd0));
         end else if (r < 12) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      p = 32'hFFFF_FFFF;
            else if (sel == 1) p = $urandom;
            else               p = 32'($urandom_range(0, 6));
            tick(1, 1, p);
         end else if (r < 16) begin
            tick(1, 2'($urandom_range(2, 3)), $urandom);
         end else begin
            tick(0, 2'($urandom_range(0, 3)), $urandom);
         end
      end

      @(negedge clk);
      cmp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
